// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first, idle high) feeding a small show-ahead FIFO.
// The serial input is synchronised, the start edge is detected, and each bit
// is sampled mid-bit. The FIFO head is always visible on rx_data_o.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  logic          sync1_q, rx_s_q, prev_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push, ferr_d, ferr_q, ovr_d, ovr_q;
  logic          fall;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q, count_d;
  logic          pop, full, do_wr;

  // Two-flop synchroniser plus previous-sample flop; all reset to idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      rx_s_q  <= sync1_q;
      prev_q  <= rx_s_q;
    end
  end

  assign fall = prev_q & ~rx_s_q;

  // Frame FSM: start qualification, mid-bit data sampling, stop check.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        cnt_d   = '0;
      end
      START: if (cnt_q == CNT_HALF) begin
        if (!rx_s_q) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = IDLE;   // glitch shorter than half a bit
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      DATA: if (cnt_q == CNT_MAX) begin
        cnt_d          = '0;
        shift_d[idx_q] = rx_s_q;
        idx_d          = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      STOP: if (cnt_q == CNT_MAX) begin
        if (rx_s_q) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = BRK;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      BRK: if (rx_s_q) state_d = IDLE;   // one error per held-low line
      default: state_d = IDLE;
    endcase
  end

  // FSM, counters and registered error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop   = rx_valid_o & rx_ready_i;
  assign full  = (count_q == CNT_FULL);
  assign do_wr = push & (~full | pop);
  assign ovr_d = push & full & ~pop;

  // Occupancy next state.
  always_comb begin
    count_d = count_q;
    case ({do_wr, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_q] <= shift_q;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign rx_data_o   = mem_q[rd_q];
  assign rx_valid_o  = (count_q != '0);
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with CLKS_PER_BIT=16, FIFO_DEPTH=4.
module tb_uart_rx_fifo;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx_i(uart_rx),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .frame_err_o(frame_err), .overrun_o(overrun), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] got[$];
  int ferr_n = 0, ovr_n = 0, vhi_n = 0;
  bit seen_v = 0;
  int first_v = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle: accepted bytes, pulses, valid occupancy.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (frame_err) ferr_n++;
      if (overrun) ovr_n++;
      if (rx_valid) vhi_n++;
      if (rx_valid && !seen_v) begin
        seen_v = 1;
        first_v = cyc;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    got.delete();
    ferr_n = 0;
    ovr_n = 0;
    vhi_n = 0;
    seen_v = 0;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is at posedge+1; returns at posedge+1 with the line high.
  task automatic send(input logic [7:0] d, input logic stop, input int extra_low);
    uart_rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      hold(CPB);
    end
    uart_rx = stop;
    hold(CPB + (stop ? 0 : extra_low));
    uart_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         extra;
    int         exp_n;
    logic [7:0] exp_d;
    int         exp_ferr;
  } vec_t;
  vec_t vt[7];

  int st;

  initial begin
    vt[0] = '{8'hA3, 1'b1, 0,  1, 8'hA3, 0};
    vt[1] = '{8'h00, 1'b1, 0,  1, 8'h00, 0};
    vt[2] = '{8'hFF, 1'b1, 0,  1, 8'hFF, 0};
    vt[3] = '{8'h80, 1'b1, 0,  1, 8'h80, 0};
    vt[4] = '{8'hA3, 1'b0, 40, 0, 8'h00, 1};
    vt[5] = '{8'h3C, 1'b1, 0,  1, 8'h3C, 0};
    vt[6] = '{8'h01, 1'b1, 0,  1, 8'h01, 0};

    // reset state
    hold(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    hold(5);

    // single byte, latency and one-cycle valid with ready high
    rx_ready = 1'b1;
    clr();
    st = cyc;
    send(8'h55, 1'b1, 0);
    hold(40);
    chk("t1_n", got.size(), 1);
    if (got.size() > 0) chk("t1_data", got[0], 8'h55);
    chk("t1_lat_win", (first_v - st >= 150) && (first_v - st <= 162), 1);
    chk("t1_vhi", vhi_n, 1);
    chk("t1_ferr", ferr_n, 0);
    chk("t1_ovr", ovr_n, 0);

    // short glitch is rejected
    clr();
    uart_rx = 1'b0;
    hold(4);
    uart_rx = 1'b1;
    hold(30);
    chk("glitch_n", got.size(), 0);
    chk("glitch_busy", busy, 0);
    chk("glitch_ferr", ferr_n, 0);

    // table of frames, ready held high
    for (int k = 0; k < 7; k++) begin
      clr();
      send(vt[k].d, vt[k].stop, vt[k].extra);
      hold(40);
      chk($sformatf("vec%0d_n", k), got.size(), vt[k].exp_n);
      if (got.size() > 0) chk($sformatf("vec%0d_data", k), got[0], vt[k].exp_d);
      chk($sformatf("vec%0d_ferr", k), ferr_n, vt[k].exp_ferr);
      chk($sformatf("vec%0d_ovr", k), ovr_n, 0);
    end

    // overrun: five back-to-back bytes into a depth-4 FIFO
    rx_ready = 1'b0;
    clr();
    for (int k = 1; k <= 4; k++) send(8'(k), 1'b1, 0);
    chk("ovr_before5", ovr_n, 0);
    send(8'h05, 1'b1, 0);
    hold(20);
    chk("ovr_pulse", ovr_n, 1);
    rx_ready = 1'b1;
    hold(10);
    chk("ovr_drain_n", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++)
      chk($sformatf("ovr_drain%0d", k), got[k], 8'(k + 1));
    chk("ovr_empty", rx_valid, 0);

    // full FIFO with a pop exactly in the stop-sample cycle
    rx_ready = 1'b0;
    clr();
    for (int k = 0; k < 4; k++) send(8'h10 + 8'(k), 1'b1, 0);
    hold(20);
    fork
      send(8'h14, 1'b1, 0);
      begin
        hold(154);
        rx_ready = 1'b1;
        hold(1);
        rx_ready = 1'b0;
      end
    join
    hold(20);
    chk("sim_ovr", ovr_n, 0);
    rx_ready = 1'b1;
    hold(10);
    chk("sim_n", got.size(), 5);
    for (int k = 0; k < 5 && k < got.size(); k++)
      chk($sformatf("sim_order%0d", k), got[k], 8'h10 + 8'(k));
    chk("sim_empty", rx_valid, 0);

    // async reset mid-frame with a byte buffered
    rx_ready = 1'b0;
    clr();
    send(8'h77, 1'b1, 0);
    hold(20);
    chk("pre_rst_valid", rx_valid, 1);
    uart_rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rx = 1'(8'hC5 >> i);
      hold(CPB);
    end
    uart_rx = 1'b0;
    hold(CPB / 2);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", rx_valid, 0);
    chk("arst_data", rx_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ferr", frame_err, 0);
    chk("arst_ovr", overrun, 0);
    uart_rx = 1'b1;
    hold(4);
    rst_n = 1'b1;
    hold(5);
    rx_ready = 1'b1;
    clr();
    send(8'h00, 1'b1, 0);
    send(8'hFF, 1'b1, 0);
    hold(40);
    chk("b2b_n", got.size(), 2);
    if (got.size() > 1) begin
      chk("b2b_0", got[0], 8'h00);
      chk("b2b_1", got[1], 8'hFF);
    end
    chk("b2b_ferr", ferr_n, 0);
    chk("b2b_ovr", ovr_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receiver that pairs with the core's `uart_tx_o` serial output: 8N1 framing, LSB first, line idles high. It recovers bytes from an asynchronous serial input and buffers them in a small show-ahead FIFO. The FIFO presents bytes to a consumer through a valid/ready handshake. It is used as the loopback/receive end in system tests and as the core's console input path.

Parameters:
CLKS_PER_BIT, 87, clock cycles per bit (10 MHz / 115200); must be >= 8
FIFO_DEPTH, 4, buffered bytes; power of two, >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
uart_rx_i  input  1  serial line, asynchronous to clk, idle high
rx_data_o  output  8  byte at FIFO head
rx_valid_o  output  1  FIFO not empty
rx_ready_i  input  1  consumer accepts head byte when high with rx_valid_o
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  one-cycle pulse: completed byte dropped because FIFO full
busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE; FIFO empties, pointers and count at 0.
  - Both synchroniser flops are set to 1.
  - rx_data_o=0, rx_valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
  - A frame in progress is discarded; reception resumes on the next falling edge after release.
- Input synchronisation: two-flop synchroniser on uart_rx_i; all logic uses the second flop (rx_s).
- Falling-edge detect: a third flop holds the previous rx_s; edge = prev high and rx_s low.
- Bit counter: 0..CLKS_PER_BIT-1. Bit index: 0..7.
- FSM states and transitions:
  - IDLE: on a falling edge go to START and clear the counter.
  - START: when the counter reaches CLKS_PER_BIT/2-1, sample rx_s (mid start bit).
    - Low: go to DATA, clear counter and bit index.
    - High: glitch; return to IDLE with no outputs asserted.
  - DATA: when the counter reaches CLKS_PER_BIT-1, shift rx_s into bit[index] (LSB first).
    - Go to STOP after index 7.
  - STOP: when the counter reaches CLKS_PER_BIT-1, sample rx_s.
    - High: push the byte and go to IDLE.
    - Low: pulse frame_err_o, discard the byte, go to BREAK.
  - BREAK: wait until rx_s is high, then go to IDLE. A held-low line generates exactly one frame_err_o.
- Push timing and overrun:
  - The push occurs in the stop-sample cycle; rx_valid_o rises the following cycle if the FIFO was empty.
  - Push while full with no pop in the same cycle: byte dropped, overrun_o pulses, FIFO contents unchanged.
  - Push while full with a pop in the same cycle: push succeeds, no overrun, count unchanged.
- FIFO (show-ahead):
  - rx_data_o always equals the head entry; its value is don't-care when empty.
  - Pop occurs when rx_valid_o and rx_ready_i are both high.
  - Simultaneous push and pop when not full or empty: count unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - rx_ready_i while empty has no effect.
- Latency: the falling edge of the start bit to rx_valid_o is about 9.5*CLKS_PER_BIT + 4 cycles (synchroniser plus edge detect plus push register).
- Pulses: frame_err_o and overrun_o are registered and high for exactly one cycle per event.
- Back-to-back frames: a start bit arriving directly after a stop bit must be received; IDLE must detect the edge on the first cycle after STOP.

Test Plan:
1. CLKS_PER_BIT=16, send 0x55 with rx_ready_i=1 -> rx_valid_o high for 1 cycle with rx_data_o=0x55, about 156 cycles after the start edge; frame_err_o and overrun_o stay 0.
2. Drive the line low for 4 cycles, then high -> FSM returns to IDLE, rx_valid_o never rises; a following 0xA3 frame is received as 0xA3.
3. Send 0xA3 with the stop bit low, holding the line low for 40 more cycles -> exactly one frame_err_o pulse, no push; after the line returns high, 0x3C is received correctly.
4. rx_ready_i=0, send 0x01..0x05 back-to-back with FIFO_DEPTH=4 -> one overrun_o pulse on 0x05. Then raise rx_ready_i -> pops return 0x01, 0x02, 0x03, 0x04, then rx_valid_o=0.
5. FIFO full (0x10..0x13); assert rx_ready_i for exactly the cycle of the 0x14 stop sample -> no overrun. Remaining order is 0x11, 0x12, 0x13, 0x14.
6. Assert rst_n=0 during bit 4 of a frame -> all outputs 0 immediately. After release, send 0x00 then 0xFF back-to-back -> both received in order, no errors.
